id_decoder: RTL and testbench

// - RV64I instruction decoder in the ID stage; sits between the IF/ID register and rename/issue.
// - Takes one fetched instruction per cycle (if_id_stage_t) and produces one decoded entry (instr_entry_t).
// - Output is registered, so the decoded entry appears one cycle after its input.
// - Flags illegal encodings as exceptions.

---
 rtl/drac_pkg.sv | 120 ++++++++++++
 rtl/id_decoder_immediate_gen.sv | 35 +++
 rtl/id_decoder.sv | 299 +++++++++++++++++++++++++++++
 tb/tb_id_decoder.sv | 137 +++++++++++++
 4 files changed

// File: rtl/drac_pkg.sv
// Shared types for the ID stage: fetch bundle, decoded entry, exceptions.
// Decoder build option: DECODER_M_EXT_EN enables the RV64M encodings.
package drac_pkg;

  localparam int XLEN          = 64;
  localparam int ADDR_SIZE     = 40;
  localparam int REGFILE_WIDTH = 5;
  localparam int INST_SIZE     = 32;

  localparam logic [6:0] OP_LUI     = 7'b0110111;
  localparam logic [6:0] OP_AUIPC   = 7'b0010111;
  localparam logic [6:0] OP_JAL     = 7'b1101111;
  localparam logic [6:0] OP_JALR    = 7'b1100111;
  localparam logic [6:0] OP_BRANCH  = 7'b1100011;
  localparam logic [6:0] OP_LOAD    = 7'b0000011;
  localparam logic [6:0] OP_STORE   = 7'b0100011;
  localparam logic [6:0] OP_ALU_I   = 7'b0010011;
  localparam logic [6:0] OP_ALU     = 7'b0110011;
  localparam logic [6:0] OP_ALU_I_W = 7'b0011011;
  localparam logic [6:0] OP_ALU_W   = 7'b0111011;
  localparam logic [6:0] OP_FENCE   = 7'b0001111;
  localparam logic [6:0] OP_SYSTEM  = 7'b1110011;

  localparam logic [6:0] F7_NORMAL = 7'b0000000;
  localparam logic [6:0] F7_SUB    = 7'b0100000;
  localparam logic [6:0] F7_MUL    = 7'b0000001;

  typedef enum logic [3:0] {
    NONE          = 4'd0,
    ILLEGAL_INSTR = 4'd2,
    BREAKPOINT    = 4'd3,
    USER_ECALL    = 4'd8
  } exception_cause_t;

  typedef enum logic {
    PRED_NOT_TAKEN = 1'b0,
    PRED_TAKEN     = 1'b1
  } branch_pred_decision_t;

  typedef enum logic [2:0] {
    UNIT_ALU    = 3'd0,
    UNIT_DIV    = 3'd1,
    UNIT_MUL    = 3'd2,
    UNIT_BRANCH = 3'd3,
    UNIT_MEM    = 3'd4,
    UNIT_SYSTEM = 3'd5
  } functional_unit_t;

  typedef enum logic [6:0] {
    ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND,
    ADDW, SUBW, SLLW, SRLW, SRAW,
    LUI, AUIPC, JAL, JALR,
    BEQ, BNE, BLT, BGE, BLTU, BGEU,
    LB, LH, LW, LD, LBU, LHU, LWU,
    SB, SH, SW, SD,
    FENCE, FENCE_I, ECALL, EBREAK, MRET, SRET, WFI,
    CSRRW, CSRRS, CSRRC, CSRRWI, CSRRSI, CSRRCI,
    MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU,
    MULW, DIVW, DIVUW, REMW, REMUW
  } instr_type_t;

  typedef enum logic [2:0] {
    IMM_NONE, IMM_I, IMM_S, IMM_B, IMM_U, IMM_J, IMM_SHAMT, IMM_SHAMTW
  } imm_fmt_t;

  typedef struct packed {
    exception_cause_t cause;
    logic [XLEN-1:0]  origin;
    logic             valid;
  } exception_t;

  typedef struct packed {
    branch_pred_decision_t decision;
    logic [ADDR_SIZE-1:0]  pred_addr;
  } bpred_t;

  typedef struct packed {
    logic [ADDR_SIZE-1:0] pc_inst;
    logic [INST_SIZE-1:0] inst;
    logic                 valid;
    exception_t           ex;
    bpred_t               bpred;
  } if_id_stage_t;

  typedef struct packed {
    logic                     valid;
    logic [ADDR_SIZE-1:0]     pc;
    bpred_t                   bpred;
    exception_t               ex;
    logic [REGFILE_WIDTH-1:0] rs1;
    logic [REGFILE_WIDTH-1:0] rs2;
    logic [REGFILE_WIDTH-1:0] rd;
    logic                     regfile_we;
    logic                     use_imm;
    logic                     use_pc;
    logic [XLEN-1:0]          imm;
    functional_unit_t         unit;
    instr_type_t              instr_type;
    logic [1:0]               mem_size;
    logic                     signed_op;
    logic                     op_32;
  } instr_entry_t;

  // Shared funct3 map of OP and OP-IMM; alt selects SUB/SRA.
  function automatic instr_type_t alu_type(logic [2:0] f3, logic alt);
    instr_type_t t;
    case (f3)
      3'b000:  t = alt ? SUB : ADD;
      3'b001:  t = SLL;
      3'b010:  t = SLT;
      3'b011:  t = SLTU;
      3'b100:  t = XOR;
      3'b101:  t = alt ? SRA : SRL;
      3'b110:  t = OR;
      default: t = AND;
    endcase
    return t;
  endfunction

endpackage

// File: rtl/id_decoder_immediate_gen.sv
// Immediate extraction for every RV64I format, sign-extended to 64 bits.
// Shift formats return the zero-extended shift amount.
module immediate_gen
  import drac_pkg::*;
(
  input  logic [31:0]     inst,
  input  imm_fmt_t        fmt,
  output logic [XLEN-1:0] imm
);

  always_comb begin
    imm = '0;
    unique case (fmt)
      IMM_I:
        imm = {{52{inst[31]}}, inst[31:20]};
      IMM_S:
        imm = {{52{inst[31]}}, inst[31:25], inst[11:7]};
      IMM_B:
        imm = {{51{inst[31]}}, inst[31], inst[7],
               inst[30:25], inst[11:8], 1'b0};
      IMM_U:
        imm = {{32{inst[31]}}, inst[31:12], 12'b0};
      IMM_J:
        imm = {{43{inst[31]}}, inst[31], inst[19:12],
               inst[20], inst[30:21], 1'b0};
      IMM_SHAMT:
        imm = {58'b0, inst[25:20]};
      IMM_SHAMTW:
        imm = {59'b0, inst[24:20]};
      default:
        imm = '0;
    endcase
  end

endmodule

// File: rtl/id_decoder.sv
// RV64I decode stage: combinational decode into a registered instr_entry_t.
// Define DECODER_M_EXT_EN to decode the RV64M multiply/divide encodings.
module id_decoder
  import drac_pkg::*;
(
  input  logic         clk_i,
  input  logic         rstn_i,
  input  if_id_stage_t decode_i,
  output instr_entry_t decode_instr_o
);

  logic [31:0]     inst;
  logic [6:0]      opcode;
  logic [2:0]      f3;
  logic [6:0]      f7;
  imm_fmt_t        fmt;
  logic [XLEN-1:0] imm;
  logic            illegal;
  logic            writes;
  logic            is_ecall;
  logic            is_ebreak;
  instr_entry_t    dec;
  instr_entry_t    nxt;

  assign inst   = decode_i.inst;
  assign opcode = inst[6:0];
  assign f3     = inst[14:12];
  assign f7     = inst[31:25];

  immediate_gen u_imm (
    .inst (inst),
    .fmt  (fmt),
    .imm  (imm)
  );

  always_comb begin
    dec       = '0;
    fmt       = IMM_NONE;
    illegal   = 1'b0;
    writes    = 1'b0;
    is_ecall  = 1'b0;
    is_ebreak = 1'b0;
    dec.valid = decode_i.valid;
    dec.pc    = decode_i.pc_inst;
    dec.bpred = decode_i.bpred;
    dec.rs1   = inst[19:15];
    dec.rs2   = inst[24:20];
    dec.rd    = inst[11:7];
    unique case (1'b1)
      opcode == OP_LUI: begin
        writes = 1'b1;
        fmt = IMM_U;
        dec.use_imm = 1'b1;
        dec.instr_type = LUI;
      end
      opcode == OP_AUIPC: begin
        writes = 1'b1;
        fmt = IMM_U;
        dec.use_imm = 1'b1;
        dec.use_pc = 1'b1;
        dec.instr_type = AUIPC;
      end
      opcode == OP_JAL: begin
        writes = 1'b1;
        fmt = IMM_J;
        dec.use_imm = 1'b1;
        dec.use_pc = 1'b1;
        dec.unit = UNIT_BRANCH;
        dec.instr_type = JAL;
      end
      opcode == OP_JALR: begin
        writes = 1'b1;
        fmt = IMM_I;
        dec.use_imm = 1'b1;
        dec.unit = UNIT_BRANCH;
        dec.instr_type = JALR;
        illegal = f3 != 3'b000;
      end
      opcode == OP_BRANCH: begin
        fmt = IMM_B;
        dec.use_pc = 1'b1;
        dec.unit = UNIT_BRANCH;
        case (f3)
          3'b000:  dec.instr_type = BEQ;
          3'b001:  dec.instr_type = BNE;
          3'b100:  dec.instr_type = BLT;
          3'b101:  dec.instr_type = BGE;
          3'b110:  dec.instr_type = BLTU;
          3'b111:  dec.instr_type = BGEU;
          default: illegal = 1'b1;
        endcase
      end
      opcode == OP_LOAD: begin
        writes = 1'b1;
        fmt = IMM_I;
        dec.use_imm = 1'b1;
        dec.unit = UNIT_MEM;
        dec.mem_size = f3[1:0];
        dec.signed_op = ~f3[2];
        case (f3)
          3'b000:  dec.instr_type = LB;
          3'b001:  dec.instr_type = LH;
          3'b010:  dec.instr_type = LW;
          3'b011:  dec.instr_type = LD;
          3'b100:  dec.instr_type = LBU;
          3'b101:  dec.instr_type = LHU;
          3'b110:  dec.instr_type = LWU;
          default: illegal = 1'b1;
        endcase
      end
      opcode == OP_STORE: begin
        fmt = IMM_S;
        dec.use_imm = 1'b1;
        dec.unit = UNIT_MEM;
        dec.mem_size = f3[1:0];
        dec.signed_op = ~f3[2];
        case (f3)
          3'b000:  dec.instr_type = SB;
          3'b001:  dec.instr_type = SH;
          3'b010:  dec.instr_type = SW;
          3'b011:  dec.instr_type = SD;
          default: illegal = 1'b1;
        endcase
      end
      opcode == OP_ALU_I: begin
        writes = 1'b1;
        fmt = IMM_I;
        dec.use_imm = 1'b1;
        dec.instr_type = alu_type(f3, f3 == 3'b101 && inst[30]);
        case (f3)
          3'b001: begin
            fmt = IMM_SHAMT;
            illegal = inst[31:26] != 6'b000000;
          end
          3'b101: begin
            fmt = IMM_SHAMT;
            illegal = inst[31:26] != 6'b000000 &&
                      inst[31:26] != 6'b010000;
          end
          default: ;
        endcase
      end
      opcode == OP_ALU: begin
        writes = 1'b1;
        case (f7)
          F7_NORMAL:
            dec.instr_type = alu_type(f3, 1'b0);
          F7_SUB: begin
            dec.instr_type = alu_type(f3, 1'b1);
            illegal = f3 != 3'b000 && f3 != 3'b101;
          end
          F7_MUL: begin
`ifdef DECODER_M_EXT_EN
            dec.unit = f3[2] ? UNIT_DIV : UNIT_MUL;
            case (f3)
              3'b000:  dec.instr_type = MUL;
              3'b001:  dec.instr_type = MULH;
              3'b010:  dec.instr_type = MULHSU;
              3'b011:  dec.instr_type = MULHU;
              3'b100:  dec.instr_type = DIV;
              3'b101:  dec.instr_type = DIVU;
              3'b110:  dec.instr_type = REM;
              default: dec.instr_type = REMU;
            endcase
`else
            illegal = 1'b1;
`endif
          end
          default: illegal = 1'b1;
        endcase
      end
      opcode == OP_ALU_I_W: begin
        writes = 1'b1;
        fmt = IMM_I;
        dec.use_imm = 1'b1;
        dec.op_32 = 1'b1;
        case (f3)
          3'b000: dec.instr_type = ADDW;
          3'b001: begin
            fmt = IMM_SHAMTW;
            dec.instr_type = SLLW;
            illegal = f7 != F7_NORMAL;
          end
          3'b101: begin
            fmt = IMM_SHAMTW;
            dec.instr_type = inst[30] ? SRAW : SRLW;
            illegal = f7 != F7_NORMAL && f7 != F7_SUB;
          end
          default: illegal = 1'b1;
        endcase
      end
      opcode == OP_ALU_W: begin
        writes = 1'b1;
        dec.op_32 = 1'b1;
        case ({f7, f3})
          {F7_NORMAL, 3'b000}: dec.instr_type = ADDW;
          {F7_NORMAL, 3'b001}: dec.instr_type = SLLW;
          {F7_NORMAL, 3'b101}: dec.instr_type = SRLW;
          {F7_SUB, 3'b000}:    dec.instr_type = SUBW;
          {F7_SUB, 3'b101}:    dec.instr_type = SRAW;
`ifdef DECODER_M_EXT_EN
          {F7_MUL, 3'b000}: begin
            dec.unit = UNIT_MUL;
            dec.instr_type = MULW;
          end
          {F7_MUL, 3'b100}: begin
            dec.unit = UNIT_DIV;
            dec.instr_type = DIVW;
          end
          {F7_MUL, 3'b101}: begin
            dec.unit = UNIT_DIV;
            dec.instr_type = DIVUW;
          end
          {F7_MUL, 3'b110}: begin
            dec.unit = UNIT_DIV;
            dec.instr_type = REMW;
          end
          {F7_MUL, 3'b111}: begin
            dec.unit = UNIT_DIV;
            dec.instr_type = REMUW;
          end
`endif
          default: illegal = 1'b1;
        endcase
      end
      opcode == OP_FENCE: begin
        dec.unit = UNIT_SYSTEM;
        case (f3)
          3'b000:  dec.instr_type = FENCE;
          3'b001:  dec.instr_type = FENCE_I;
          default: illegal = 1'b1;
        endcase
      end
      opcode == OP_SYSTEM: begin
        dec.unit = UNIT_SYSTEM;
        if (f3 == 3'b000) begin
          case (inst[31:7])
            25'h0000000: begin
              dec.instr_type = ECALL;
              is_ecall = 1'b1;
            end
            25'h0002000: begin
              dec.instr_type = EBREAK;
              is_ebreak = 1'b1;
            end
            25'h0604000: dec.instr_type = MRET;
            25'h0204000: dec.instr_type = SRET;
            25'h020A000: dec.instr_type = WFI;
            default:     illegal = 1'b1;
          endcase
        end else begin
          writes = 1'b1;
          fmt = IMM_I;
          dec.use_imm = 1'b1;
          case (f3)
            3'b001:  dec.instr_type = CSRRW;
            3'b010:  dec.instr_type = CSRRS;
            3'b011:  dec.instr_type = CSRRC;
            3'b101:  dec.instr_type = CSRRWI;
            3'b110:  dec.instr_type = CSRRSI;
            3'b111:  dec.instr_type = CSRRCI;
            default: illegal = 1'b1;
          endcase
        end
      end
      default: illegal = 1'b1;
    endcase
    dec.regfile_we = writes && !illegal && (dec.rd != '0);
  end

  // Fetch faults outrank decode faults, which outrank ecall/ebreak.
  always_comb begin
    nxt = dec;
    nxt.imm = imm;
    nxt.ex = '0;
    if (decode_i.ex.valid) begin
      nxt.ex = decode_i.ex;
    end else if (illegal) begin
      nxt.ex.valid = 1'b1;
      nxt.ex.cause = ILLEGAL_INSTR;
      nxt.ex.origin = {32'b0, inst};
    end else if (is_ecall) begin
      nxt.ex.valid = 1'b1;
      nxt.ex.cause = USER_ECALL;
      nxt.ex.origin = {24'b0, decode_i.pc_inst};
    end else if (is_ebreak) begin
      nxt.ex.valid = 1'b1;
      nxt.ex.cause = BREAKPOINT;
      nxt.ex.origin = {24'b0, decode_i.pc_inst};
    end
    if (!decode_i.valid) nxt.ex.valid = 1'b0;
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) decode_instr_o <= '0;
    else         decode_instr_o <= nxt;
  end

endmodule

// File: tb/tb_id_decoder.sv
// Directed-vector bench for the RV64I decode stage.
// Each task drives instructions and checks the registered decode.
module tb_id_decoder;
  import drac_pkg::*;

  logic         clk = 1'b0;
  logic         rstn = 1'b0;
  if_id_stage_t din;
  instr_entry_t dout;
  int           n_checks = 0;
  int           n_fail = 0;

  always #5 clk = ~clk;

  id_decoder dut (
    .clk_i          (clk),
    .rstn_i         (rstn),
    .decode_i       (din),
    .decode_instr_o (dout)
  );

  task automatic drive(input logic [31:0] i, input logic [39:0] p,
                       input logic v, input exception_t ex);
    @(negedge clk);
    din = '0;
    din.inst = i;
    din.pc_inst = p;
    din.valid = v;
    din.ex = ex;
    din.bpred.decision = PRED_TAKEN;
    din.bpred.pred_addr = p + 40'd4;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    drive(32'h00100093, 40'h100, 1'b1, '0);
    n_checks++; if (dout.valid !== 1'b0) begin n_fail++; $display("FAIL rst_valid got %b exp 0", dout.valid); end
    n_checks++; if (dout.ex.valid !== 1'b0) begin n_fail++; $display("FAIL rst_ex got %b exp 0", dout.ex.valid); end
    n_checks++; if (dout.regfile_we !== 1'b0) begin n_fail++; $display("FAIL rst_we got %b exp 0", dout.regfile_we); end
    n_checks++; if (dout.instr_type !== ADD || dout.unit !== UNIT_ALU) begin n_fail++; $display("FAIL rst_type got %0d/%0d exp ADD/ALU", dout.instr_type, dout.unit); end
    @(negedge clk);
    rstn = 1'b1;
    #1;
    n_checks++; if (dout.valid !== 1'b0) begin n_fail++; $display("FAIL rel_early got %b exp 0", dout.valid); end
    @(posedge clk);
    #1;
    n_checks++; if (dout.valid !== 1'b1 || dout.rd !== 5'd1) begin n_fail++; $display("FAIL rel_first got v%b rd%0d exp v1 rd1", dout.valid, dout.rd); end
  endtask

  task automatic test_alu_imm();
    drive(32'hfff02013, 40'h2010, 1'b1, '0);
    n_checks++; if (dout.instr_type !== SLT || dout.unit !== UNIT_ALU) begin n_fail++; $display("FAIL slti_type got %0d/%0d exp SLT/ALU", dout.instr_type, dout.unit); end
    n_checks++; if (dout.imm !== 64'hFFFF_FFFF_FFFF_FFFF || dout.use_imm !== 1'b1) begin n_fail++; $display("FAIL slti_imm got %h/%b exp all-ones/1", dout.imm, dout.use_imm); end
    n_checks++; if (dout.rs1 !== 5'd0 || dout.rd !== 5'd0 || dout.regfile_we !== 1'b0) begin n_fail++; $display("FAIL slti_regs got rs1 %0d rd %0d we %b exp 0 0 0", dout.rs1, dout.rd, dout.regfile_we); end
    n_checks++; if (dout.pc !== 40'h2010 || dout.ex.valid !== 1'b0) begin n_fail++; $display("FAIL slti_pc got %h ex %b exp 2010 0", dout.pc, dout.ex.valid); end
    n_checks++; if (dout.bpred.pred_addr !== 40'h2014 || dout.bpred.decision !== PRED_TAKEN) begin n_fail++; $display("FAIL slti_bpred got %h/%0d exp 2014/1", dout.bpred.pred_addr, dout.bpred.decision); end
  endtask

  task automatic test_back_to_back();
    drive(32'h00003013, 40'h2014, 1'b1, '0);
    n_checks++; if (dout.instr_type !== SLTU || dout.imm !== 64'd0) begin n_fail++; $display("FAIL sltiu got %0d imm %h exp SLTU 0", dout.instr_type, dout.imm); end
    drive(32'h00500013, 40'h2018, 1'b1, '0);
    n_checks++; if (dout.instr_type !== ADD || dout.imm !== 64'd5) begin n_fail++; $display("FAIL addi got %0d imm %h exp ADD 5", dout.instr_type, dout.imm); end
    drive(32'h00804013, 40'h201c, 1'b1, '0);
    n_checks++; if (dout.instr_type !== XOR || dout.imm !== 64'd8) begin n_fail++; $display("FAIL xori got %0d imm %h exp XOR 8", dout.instr_type, dout.imm); end
    drive(32'h00100093, 40'h2020, 1'b1, '0);
    n_checks++; if (dout.rd !== 5'd1 || dout.regfile_we !== 1'b1) begin n_fail++; $display("FAIL addi_x1 got rd %0d we %b exp 1 1", dout.rd, dout.regfile_we); end
  endtask

  task automatic test_illegal();
    exception_t fx;
    drive(32'h00000000, 40'h3000, 1'b1, '0);
    n_checks++; if (dout.ex.valid !== 1'b1 || dout.ex.cause !== ILLEGAL_INSTR) begin n_fail++; $display("FAIL zero_inst got %b/%0d exp 1/ILLEGAL", dout.ex.valid, dout.ex.cause); end
    n_checks++; if (dout.regfile_we !== 1'b0) begin n_fail++; $display("FAIL zero_we got %b exp 0", dout.regfile_we); end
    fx.valid = 1'b1;
    fx.cause = BREAKPOINT;
    fx.origin = 64'hABC;
    drive(32'h00000000, 40'h3004, 1'b1, fx);
    n_checks++; if (dout.ex.cause !== BREAKPOINT || dout.ex.origin !== 64'hABC || dout.ex.valid !== 1'b1) begin n_fail++; $display("FAIL ex_pass got %0d %h exp BREAKPOINT abc", dout.ex.cause, dout.ex.origin); end
    drive(32'h00000000, 40'h3008, 1'b0, '0);
    n_checks++; if (dout.valid !== 1'b0 || dout.ex.valid !== 1'b0) begin n_fail++; $display("FAIL invalid got v%b ex%b exp 0 0", dout.valid, dout.ex.valid); end
  endtask

  task automatic test_m_ext();
    drive(32'h02208033, 40'h4000, 1'b1, '0);
`ifdef DECODER_M_EXT_EN
    n_checks++; if (dout.instr_type !== MUL || dout.unit !== UNIT_MUL || dout.ex.valid !== 1'b0) begin n_fail++; $display("FAIL mul got %0d/%0d ex %b exp MUL/MUL 0", dout.instr_type, dout.unit, dout.ex.valid); end
`else
    n_checks++; if (dout.ex.valid !== 1'b1 || dout.ex.cause !== ILLEGAL_INSTR) begin n_fail++; $display("FAIL mul_off got %b/%0d exp 1/ILLEGAL", dout.ex.valid, dout.ex.cause); end
`endif
  endtask

  task automatic test_shifts();
    drive(32'h03F11093, 40'h5000, 1'b1, '0);
    n_checks++; if (dout.instr_type !== SLL || dout.imm !== 64'd63 || dout.op_32 !== 1'b0) begin n_fail++; $display("FAIL slli got %0d imm %h w %b exp SLL 3f 0", dout.instr_type, dout.imm, dout.op_32); end
    drive(32'h4051509B, 40'h5004, 1'b1, '0);
    n_checks++; if (dout.instr_type !== SRAW || dout.imm !== 64'd5 || dout.op_32 !== 1'b1) begin n_fail++; $display("FAIL sraiw got %0d imm %h w %b exp SRAW 5 1", dout.instr_type, dout.imm, dout.op_32); end
  endtask

  task automatic test_ctrl_mem();
    drive(32'hFE208EE3, 40'h6000, 1'b1, '0);
    n_checks++; if (dout.instr_type !== BEQ || dout.unit !== UNIT_BRANCH || dout.use_pc !== 1'b1) begin n_fail++; $display("FAIL beq got %0d/%0d pc %b exp BEQ/BRANCH 1", dout.instr_type, dout.unit, dout.use_pc); end
    n_checks++; if (dout.imm !== 64'hFFFF_FFFF_FFFF_FFFC || dout.regfile_we !== 1'b0) begin n_fail++; $display("FAIL beq_imm got %h we %b exp -4 0", dout.imm, dout.regfile_we); end
    drive(32'h0080A283, 40'h6004, 1'b1, '0);
    n_checks++; if (dout.instr_type !== LW || dout.unit !== UNIT_MEM || dout.mem_size !== 2'd2 || dout.signed_op !== 1'b1) begin n_fail++; $display("FAIL lw got %0d/%0d sz %0d s %b exp LW/MEM 2 1", dout.instr_type, dout.unit, dout.mem_size, dout.signed_op); end
    n_checks++; if (dout.imm !== 64'd8 || dout.rd !== 5'd5 || dout.regfile_we !== 1'b1) begin n_fail++; $display("FAIL lw_imm got %h rd %0d we %b exp 8 5 1", dout.imm, dout.rd, dout.regfile_we); end
    drive(32'h0020B823, 40'h6008, 1'b1, '0);
    n_checks++; if (dout.instr_type !== SD || dout.imm !== 64'd16 || dout.mem_size !== 2'd3 || dout.regfile_we !== 1'b0) begin n_fail++; $display("FAIL sd got %0d imm %h sz %0d we %b exp SD 10 3 0", dout.instr_type, dout.imm, dout.mem_size, dout.regfile_we); end
    drive(32'h800001B7, 40'h600c, 1'b1, '0);
    n_checks++; if (dout.imm !== 64'hFFFF_FFFF_8000_0000 || dout.unit !== UNIT_ALU || dout.rd !== 5'd3) begin n_fail++; $display("FAIL lui got %h/%0d rd %0d exp ffffffff80000000/ALU 3", dout.imm, dout.unit, dout.rd); end
    drive(32'h001000EF, 40'h6010, 1'b1, '0);
    n_checks++; if (dout.instr_type !== JAL || dout.imm !== 64'd2048 || dout.use_pc !== 1'b1 || dout.regfile_we !== 1'b1) begin n_fail++; $display("FAIL jal got %0d imm %h pc %b we %b exp JAL 800 1 1", dout.instr_type, dout.imm, dout.use_pc, dout.regfile_we); end
  endtask

  task automatic test_system();
    drive(32'h00000073, 40'h7000, 1'b1, '0);
    n_checks++; if (dout.ex.valid !== 1'b1 || dout.ex.cause !== USER_ECALL || dout.ex.origin !== 64'h7000) begin n_fail++; $display("FAIL ecall got %b/%0d %h exp 1/ECALL 7000", dout.ex.valid, dout.ex.cause, dout.ex.origin); end
    drive(32'h00100073, 40'h7004, 1'b1, '0);
    n_checks++; if (dout.ex.cause !== BREAKPOINT || dout.ex.origin !== 64'h7004 || dout.unit !== UNIT_SYSTEM) begin n_fail++; $display("FAIL ebreak got %0d %h unit %0d exp BREAKPOINT 7004 SYSTEM", dout.ex.cause, dout.ex.origin, dout.unit); end
  endtask

  initial begin
    din = '0;
    test_reset();
    test_alu_imm();
    test_back_to_back();
    test_illegal();
    test_m_ext();
    test_shifts();
    test_ctrl_mem();
    test_system();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
